i2s_tx_stage: RTL and testbench
===============================

Name: i2s_tx_stage

Overview:
- Downstream audio output stage between the Nios system (clk_100m domain) and the external codec DAC.
- Accepts stereo PCM frames over a valid/ready handshake and buffers them in a small FIFO.
- Serialises the frames as standard Philips I2S and generates BCLK and LRCLK from the system clock.
- Reports FIFO fill level and underrun status back to software.

Parameters:
- DATA_W, 16: sample width per channel; legal range 8..24.
- FIFO_DEPTH, 16: stereo frames buffered; power of two, minimum 4.
- BCLK_HALF_DIV, 16: sys_clk cycles per BCLK half period. 100 MHz/32 gives 3.125 MHz BCLK and a 48.8 kHz frame rate.

Ports:
- sys_clk  in  1  system clock (clk_100m).
- sys_rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  frame-write request.
- s_ready  out  1  FIFO can accept a frame.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample.
- tx_en  in  1  serialiser enable.
- underrun_clr  in  1  clears the sticky underrun flag.
- underrun  out  1  sticky: a frame was due while the FIFO was empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left.
- i2s_sdata  out  1  serial data.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level=0, s_ready=1, underrun=0, i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, div_cnt=0, bit position p=63, holding registers=0.
- Write handshake:
  - A push occurs when s_valid && s_ready on a sys_clk edge.
  - s_ready = !full, registered-state based.
  - When full, a push is refused even if a pop happens in the same cycle.
  - fifo_level updates the cycle after a push or pop. Push and pop in the same cycle leave the level unchanged.
- BCLK generation (only while tx_en=1):
  - div_cnt counts 0..BCLK_HALF_DIV-1.
  - On reaching the terminal count, div_cnt wraps and i2s_bclk toggles.
  - A toggle 1->0 is a "fall event".
- Fall event actions:
  - p increments mod 64.
  - i2s_lrclk <= (p_next >= 32).
  - i2s_sdata <= the bit for p_next.
- Data mapping:
  - p=1..DATA_W carry left[DATA_W-1..0], MSB first.
  - p=33..32+DATA_W carry right, MSB first.
  - All other positions carry 0.
  - Outputs change only at fall events, so the codec samples on the BCLK rising edge.
- Frame load, at the fall event where p_next=0:
  - If FIFO is non-empty: pop one frame into the left/right holding registers.
  - If FIFO is empty: load zeros and set underrun.
- Underrun flag:
  - underrun stays set until underrun_clr=1.
  - If clear and set coincide, set wins.
- Simultaneous push into an empty FIFO at a load event: the pop sees empty (underrun), and the pushed frame stays stored for the next frame.
- tx_en=0:
  - div_cnt, p, i2s_bclk and i2s_lrclk freeze; i2s_sdata holds.
  - No pops occur; pushes continue.
  - On re-enable, operation resumes from the frozen state.
- Reset mid-frame: all state returns to reset values immediately (async). FIFO contents are discarded.
- Arithmetic: no sample scaling or saturation; samples pass bit-exact.

Decomposition:
- Shared package audio_pkg holds:
  - constant SLOT_BITS=32 and FRAME_BITS=64;
  - constant LEFT_MSB_POS=1;
  - a typedef for the stereo frame {left, right} of width 2*DATA_W_MAX (24).
- One natural sub-module: sync_fifo (width 2*DATA_W, depth FIFO_DEPTH, level output). It is reusable for a future i2s_rx_stage.

Test Plan:
- Push one frame L=16'hA5C3, R=16'h0F0F after reset, tx_en=1 (defaults):
  - first bclk rise at cycle 16, first fall at cycle 32;
  - pop happens at cycle 32 and lrclk goes 0;
  - sdata shows 1010010111000011 at p=1..16, then zeros;
  - lrclk goes 1 at p=32, and R appears at p=33..48.
- Fill the FIFO with 16 frames while tx_en=0:
  - s_ready drops after the 16th push and fifo_level=16;
  - the 17th push is ignored;
  - after tx_en=1, level reads 15 after the first frame load.
- Run with an empty FIFO:
  - underrun=1 after the first load and sdata is all-zero;
  - pulse underrun_clr with the FIFO still empty: underrun reasserts at the next p=0.
- Push into an empty FIFO in the same cycle as a p=0 fall event:
  - underrun=1, level=1;
  - the frame is transmitted in the following frame.
- Assert sys_rst low mid-frame at p=20: all outputs return to reset values asynchronously and fifo_level=0.
- DATA_W=24, BCLK_HALF_DIV=2:
  - a 24-bit MSB-first pattern 24'h800001 appears at p=1..24;
  - lrclk period = 256 sys_clk cycles.

Source files
------------

// File: rtl/i2s_tx_stage_pkg.sv
// Shared audio definitions: I2S frame geometry, the stereo frame type and slot bit mapping.
package audio_pkg;
  localparam int SLOT_BITS    = 32;
  localparam int FRAME_BITS   = 64;
  localparam int LEFT_MSB_POS = 1;
  localparam int DATA_W_MAX   = 24;

  typedef struct packed {
    logic [DATA_W_MAX-1:0] left;
    logic [DATA_W_MAX-1:0] right;
  } stereo_frame_t;

  // Serial bit for frame position pos; samples are right-aligned in the frame fields.
  function automatic logic slot_bit(input stereo_frame_t f, input logic [5:0] pos,
                                    input int data_w);
    logic [5:0] lo;
    logic [5:0] ro;
    logic [5:0] dw;
    logic [4:0] idx;
    logic       b;
    lo  = 6'(LEFT_MSB_POS);
    ro  = 6'(LEFT_MSB_POS + SLOT_BITS);
    dw  = 6'(data_w);
    idx = '0;
    b   = 1'b0;
    if (pos >= lo && pos < lo + dw) begin
      idx = 5'(dw + lo - 6'd1 - pos);
      b   = f.left[idx];
    end else if (pos >= ro && pos < ro + dw) begin
      idx = 5'(dw + ro - 6'd1 - pos);
      b   = f.right[idx];
    end
    return b;
  endfunction
endpackage

// File: rtl/i2s_tx_stage_if.sv
// Stereo frame write handshake into the I2S transmit stage.
interface i2s_tx_stage_if #(parameter int DATA_W = 16);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_stage_sync_fifo.sv
// Single-clock FIFO with occupancy output; data_o shows the head entry combinationally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/i2s_tx_stage.sv
// Buffers stereo PCM frames and serialises them as Philips I2S with BCLK/LRCLK derived from sys_clk.
module i2s_tx_stage
  import audio_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int BCLK_HALF_DIV = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  i2s_tx_stage_if.slave                 s_bus,
  input  logic                          tx_en,
  input  logic                          underrun_clr,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata
);
  localparam int DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [5:0] P_LAST = 6'(FRAME_BITS - 1);

  logic [DIV_W-1:0]    div_q;
  logic [5:0]          p_q;
  logic [5:0]          p_d;
  logic                bclk_q;
  logic                lrclk_q;
  logic                sdata_q;
  logic                underrun_q;
  stereo_frame_t       frame_q;
  stereo_frame_t       frame_d;
  logic                tick;
  logic                fall;
  logic                load;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] fifo_dout;

  sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst),
    .push_i  (s_bus.s_valid),
    .data_i  ({s_bus.s_left, s_bus.s_right}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    tick     = tx_en && (div_q == DIV_TC);
    fall     = tick && bclk_q;
    p_d      = p_q + 6'd1;
    load     = fall && (p_d == '0);
    fifo_pop = load && !fifo_empty;
    // An empty FIFO at a frame boundary sends a silent frame.
    frame_d  = '0;
    if (!fifo_empty) begin
      frame_d.left[DATA_W-1:0]  = fifo_dout[2*DATA_W-1 -: DATA_W];
      frame_d.right[DATA_W-1:0] = fifo_dout[DATA_W-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      p_q        <= P_LAST;
      frame_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (tx_en) div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick)  bclk_q <= !bclk_q;
      if (fall) begin
        p_q     <= p_d;
        lrclk_q <= (p_d >= 6'(SLOT_BITS));
        sdata_q <= slot_bit(frame_q, p_d, DATA_W);
      end
      if (load) frame_q <= frame_d;
      if (load && fifo_empty) underrun_q <= 1'b1;
      else if (underrun_clr)  underrun_q <= 1'b0;
    end
  end

  assign s_bus.s_ready = !fifo_full;
  assign underrun      = underrun_q;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lrclk_q;
  assign i2s_sdata     = sdata_q;
endmodule

// File: tb/tb_i2s_tx_stage.sv
// Self-checking bench: FIFO/underrun reference model plus a serial-frame scoreboard.
module tb_i2s_tx_stage;
  localparam int DEPTH = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       rst_n, tx_en, underrun_clr, underrun;
  logic [4:0] fifo_level;
  logic       bclk, lrclk, sdata;
  logic       rst2_n, tx_en2, clr2, underrun2;
  logic [4:0] level2;
  logic       bclk2, lrclk2, sdata2;

  i2s_tx_stage_if #(.DATA_W(16)) bus ();
  i2s_tx_stage_if #(.DATA_W(24)) bus2 ();

  i2s_tx_stage #(.DATA_W(16), .FIFO_DEPTH(16), .BCLK_HALF_DIV(16)) dut (
    .sys_clk(sys_clk), .sys_rst(rst_n), .s_bus(bus), .tx_en(tx_en),
    .underrun_clr(underrun_clr), .underrun(underrun), .fifo_level(fifo_level),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata));

  i2s_tx_stage #(.DATA_W(24), .FIFO_DEPTH(16), .BCLK_HALF_DIV(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(rst2_n), .s_bus(bus2), .tx_en(tx_en2),
    .underrun_clr(clr2), .underrun(underrun2), .fifo_level(level2),
    .i2s_bclk(bclk2), .i2s_lrclk(lrclk2), .i2s_sdata(sdata2));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: FIFO contents, underrun flag and the frame expected at each load.
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic        und_m = 1'b0;
  logic        lr_prev_m = 1'b1;
  int          cyc;

  always @(posedge sys_clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge rst_n) begin
    model_q.delete();
    exp_q.delete();
    und_m     = 1'b0;
    lr_prev_m = 1'b1;
  end

  always begin : model
    logic        pv, pc, ld, was_full, was_empty;
    logic [31:0] pd;
    @(posedge sys_clk);
    pv = bus.s_valid;
    pd = {bus.s_left, bus.s_right};
    pc = underrun_clr;
    #1;
    if (rst_n) begin
      ld        = lr_prev_m && !lrclk;
      lr_prev_m = lrclk;
      was_full  = (model_q.size() >= DEPTH);
      was_empty = (model_q.size() == 0);
      if (ld) begin
        if (was_empty) exp_q.push_back('0);
        else           exp_q.push_back(model_q.pop_front());
      end
      if (ld && was_empty) und_m = 1'b1;
      else if (pc)         und_m = 1'b0;
      if (pv && !was_full) model_q.push_back(pd);
      check("level", fifo_level, model_q.size());
      check("ready", bus.s_ready, model_q.size() < DEPTH);
      check("underrun", underrun, und_m);
    end
  end

  // Serial monitor: capture 64 bits per frame on BCLK rise, starting at the LRCLK fall.
  int          mon_idx = 0;
  int          frames_done = 0;
  bit          mon_on = 1'b0;
  logic        mon_lr_prev = 1'b1;
  logic [63:0] mon_word, mon_lrw;

  always @(posedge bclk or negedge rst_n) begin : mon
    logic [31:0] f;
    if (!rst_n) begin
      mon_on = 1'b0;
      mon_idx = 0;
      mon_lr_prev = 1'b1;
    end else begin
      if (mon_lr_prev && !lrclk) begin
        mon_on = 1'b1;
        mon_idx = 0;
      end
      mon_lr_prev = lrclk;
      if (mon_on) begin
        mon_word[63-mon_idx] = sdata;
        mon_lrw[63-mon_idx]  = lrclk;
        if (mon_idx == 63) begin
          check("frame_avail", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            check("frame_data", mon_word, {1'b0, f[31:16], 15'b0, 1'b0, f[15:0], 15'b0});
            check("frame_lrclk", mon_lrw, 64'h0000_0000_FFFF_FFFF);
          end
          frames_done++;
          mon_on = 1'b0;
          mon_idx = 0;
        end else begin
          mon_idx++;
        end
      end
    end
  end

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_level(input logic [4:0] lv, input int budget, input string tag);
    int n = 0;
    while (fifo_level !== lv && n < budget) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check(tag, fifo_level, lv);
  endtask

  initial begin
    int          n, fsnap, f1, f2, k;
    logic        bclk_frz, lr_frz, lr2_prev, bclk2_prev;
    logic [63:0] w2;
    rst_n = 1'b0; tx_en = 1'b1; underrun_clr = 1'b0;
    bus.s_valid = 1'b0; bus.s_left = '0; bus.s_right = '0;
    rst2_n = 1'b0; tx_en2 = 1'b1; clr2 = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_left = '0; bus2.s_right = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_level", fifo_level, 0);
    check("rst_ready", bus.s_ready, 1);
    check("rst_underrun", underrun, 0);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 1);
    check("rst_sdata", sdata, 0);

    // Single frame: timing of first BCLK edges and the load
    @(negedge sys_clk);
    bus.s_valid = 1'b1; bus.s_left = 16'hA5C3; bus.s_right = 16'h0F0F; rst_n = 1'b1;
    goto_cycle(1);
    bus.s_valid = 1'b0;
    check("t1_level", fifo_level, 1);
    goto_cycle(15); check("t1_bclk15", bclk, 0);
    goto_cycle(16); check("t1_bclk16", bclk, 1);
    goto_cycle(31); check("t1_bclk31", bclk, 1); check("t1_lrclk31", lrclk, 1);
    goto_cycle(32); check("t1_bclk32", bclk, 0); check("t1_lrclk32", lrclk, 0);
    check("t1_pop_level", fifo_level, 0);
    goto_cycle(2070); check("t1_frames", frames_done, 1);
    goto_cycle(2200); check("t1_underrun", underrun, 1);

    // Fill while disabled: 17th push refused, serialiser frozen
    @(negedge sys_clk);
    tx_en = 1'b0;
    bclk_frz = bclk; lr_frz = lrclk;
    for (int i = 0; i < 17; i++) begin
      @(negedge sys_clk);
      bus.s_valid = 1'b1;
      bus.s_left = 16'(16'h1000 + i);
      bus.s_right = 16'(16'h2000 + i);
      @(posedge sys_clk);
      #1;
      if (i == 15) begin
        check("fill_ready", bus.s_ready, 0);
        check("fill_level16", fifo_level, 16);
      end
    end
    bus.s_valid = 1'b0;
    repeat (50) @(negedge sys_clk);
    check("fill_level17", fifo_level, 16);
    check("freeze_bclk", bclk, bclk_frz);
    check("freeze_lrclk", lrclk, lr_frz);
    tx_en = 1'b1;
    wait_level(5'd15, 3000, "fill_level15");
    wait_level(5'd14, 3000, "fill_level14");

    // Asynchronous reset mid-frame at p=20
    n = 0;
    while (mon_idx != 21 && n < 1000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("mid_p20_reached", mon_idx, 21);
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_bclk", bclk, 0);
    check("mid_lrclk", lrclk, 1);
    check("mid_sdata", sdata, 0);
    check("mid_underrun", underrun, 0);
    check("mid_ready", bus.s_ready, 1);
    check("mid_level", fifo_level, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;

    // Underrun with empty FIFO, clear then reassert
    goto_cycle(31); check("ur_before", underrun, 0);
    goto_cycle(32); check("ur_set", underrun, 1);
    goto_cycle(99); underrun_clr = 1'b1;
    goto_cycle(100); underrun_clr = 1'b0; check("ur_clr", underrun, 0);
    goto_cycle(2079); check("ur_still_clr", underrun, 0);
    goto_cycle(2080); check("ur_reassert", underrun, 1);
    goto_cycle(2999); underrun_clr = 1'b1;
    goto_cycle(3000); underrun_clr = 1'b0; check("ur_clr2", underrun, 0);

    // Push coincident with the p=0 load
    goto_cycle(4127);
    bus.s_valid = 1'b1; bus.s_left = 16'h8001; bus.s_right = 16'h7FFE;
    goto_cycle(4128);
    bus.s_valid = 1'b0;
    check("p0_underrun", underrun, 1);
    check("p0_level", fifo_level, 1);
    goto_cycle(6170); fsnap = frames_done;
    check("p0_level_held", fifo_level, 1);
    goto_cycle(6176); check("p0_next_pop", fifo_level, 0);
    goto_cycle(8230); check("p0_frame_sent", frames_done, fsnap + 1);

    // 24-bit, fast BCLK instance
    tx_en = 1'b0;
    @(negedge sys_clk);
    bus2.s_valid = 1'b1; bus2.s_left = 24'h800001; bus2.s_right = 24'h5A5A5A; rst2_n = 1'b1;
    f1 = -1; f2 = -1; k = 0; w2 = '0; lr2_prev = 1'b1; bclk2_prev = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      @(posedge sys_clk);
      #1;
      if (c == 1) bus2.s_valid = 1'b0;
      if (lr2_prev && !lrclk2) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
      lr2_prev = lrclk2;
      if (!bclk2_prev && bclk2 && f1 >= 0 && k < 64) begin
        w2[63-k] = sdata2;
        k++;
      end
      bclk2_prev = bclk2;
    end
    check("w24_first_fall", f1, 4);
    check("w24_lr_period", f2 - f1, 256);
    check("w24_bits", k, 64);
    check("w24_word", w2, {1'b0, 24'h800001, 7'b0, 1'b0, 24'h5A5A5A, 7'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
